// File: rtl/dds_pkg.sv
// Shared encodings and helpers for the DDS waveform generator.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SAW    = 2'b11
  } mode_t;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  // Offset-binary zero level for a DAC of the given width.
  function automatic int unsigned midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dds_sin_rom.sv
// Synchronous-read offset-binary sine table, 2^ADDR_W entries of DAC_W bits.
module dds_sin_rom
  import dds_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DAC_W  = 14
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DAC_W-1:0]  data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Bhaskara half-wave approximation; exact at 0, quarter and half period.
  function automatic logic [DAC_W-1:0] sine_entry(input int idx);
    longint half, u, num, den, peak, val;
    half = longint'(DEPTH / 2);
    u    = longint'(idx) % half;
    num  = 64'sd16 * u * (half - u);
    den  = 64'sd5 * half * half - 64'sd4 * u * (half - u);
    peak = (64'sd1 <<< (DAC_W - 1)) - 64'sd1;
    val  = (peak * num + den / 64'sd2) / den;
    if (longint'(idx) < half) return DAC_W'(longint'(midscale(DAC_W)) + val);
    else                      return DAC_W'(longint'(midscale(DAC_W)) - val);
  endfunction

  logic [DAC_W-1:0] sin_table [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    assign sin_table[i] = sine_entry(i);
  end

  // NOTE: ROM read port carries no reset so it maps onto block memory; downstream valid gating hides its power-up value.
  always_ff @(posedge clk) begin
    data <= sin_table[addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, shadowed config, 3-stage sample pipeline.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int FREQ_W  = 24,
  parameter int ADDR_W  = 9,
  parameter int DAC_W   = 14,
  parameter int AMP_W   = 8,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_load,
  input  logic               cfg_immediate,
  input  logic [FREQ_W-1:0]  cfg_freq,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_busy,
  input  logic               sync,
  output logic [DAC_W-1:0]   dac_out,
  output logic               dac_valid,
  output logic               wrap
);

  localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));
  localparam int PROD_W = DAC_W + AMP_W + 2;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] phase;
    mode_t              mode;
  } cfg_t;

  cfg_t       cfg_in, shadow, active;
  cfg_state_t state, state_next;
  logic       boundary, load_now, apply_shadow, wrap_evt;
  logic [ACC_W-1:0] acc, acc_sum;
  logic       carry, acc_wrapped;

  assign cfg_in = '{freq: cfg_freq, amp: cfg_amp, phase: cfg_phase, mode: mode_t'(cfg_mode)};

  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, ACC_W'(active.freq)};
  assign wrap_evt = en && !sync && carry;

  // A sync, a disabled accumulator or a wrap are all safe points to swap config.
  // With a zero tuning word no wrap ever comes, so a deferred load applies at once.
  assign boundary     = sync || !en || wrap_evt;
  assign load_now     = cfg_load && (cfg_immediate || active.freq == '0 || boundary);
  assign apply_shadow = (state == CFG_PENDING) && !cfg_load && boundary;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CFG_IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting state_next first keeps this block purely combinational (no latch).
  always_comb begin
    state_next = state;
    if (cfg_load)          state_next = load_now ? CFG_IDLE : CFG_PENDING;
    else if (apply_shadow) state_next = CFG_IDLE;
  end

  always_comb begin
    cfg_busy = (state == CFG_PENDING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (cfg_load) shadow <= cfg_in;
      if (load_now)          active <= cfg_in;
      else if (apply_shadow) active <= shadow;
    end
  end

  // acc_wrapped marks that the current acc value is the result of an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      acc_wrapped <= 1'b0;
    end else if (sync) begin
      acc         <= '0;
      acc_wrapped <= 1'b0;
    end else if (en) begin
      acc         <= acc_sum;
      acc_wrapped <= carry;
    end
  end

  logic [ADDR_W-1:0] phase_off, phase_addr;

  if (ADDR_W >= PHASE_W) begin : g_off_shl
    assign phase_off = ADDR_W'(active.phase) << (ADDR_W - PHASE_W);
  end else begin : g_off_shr
    assign phase_off = ADDR_W'(active.phase >> (PHASE_W - ADDR_W));
  end

  assign phase_addr = acc[ACC_W-1 -: ADDR_W] + phase_off;

  logic              s1_valid, s1_wrap;
  logic [ADDR_W-1:0] s1_p;
  mode_t             s1_mode;
  logic [AMP_W-1:0]  s1_amp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
      s1_p     <= '0;
      s1_mode  <= MODE_SINE;
      s1_amp   <= '0;
    end else if (!en) begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
    end else begin
      s1_valid <= 1'b1;
      s1_wrap  <= acc_wrapped;
      s1_p     <= phase_addr;
      s1_mode  <= active.mode;
      s1_amp   <= active.amp;
    end
  end

  logic [DAC_W-1:0] rom_data;

  dds_sin_rom #(.ADDR_W(ADDR_W), .DAC_W(DAC_W)) u_rom (
    .clk  (clk),
    .addr (s1_p),
    .data (rom_data)
  );

  logic [ADDR_W-1:0] tri_p;
  logic [DAC_W-1:0]  shape_raw;

  always_comb begin
    tri_p = s1_p[ADDR_W-1] ? ~(s1_p << 1) : (s1_p << 1);
    case (s1_mode)
      MODE_SQUARE: shape_raw = s1_p[ADDR_W-1] ? '0 : '1;
      MODE_TRI:    shape_raw = DAC_W'(tri_p) << (DAC_W - ADDR_W);
      default:     shape_raw = DAC_W'(s1_p) << (DAC_W - ADDR_W);
    endcase
  end

  logic             s2_valid, s2_wrap;
  mode_t            s2_mode;
  logic [AMP_W-1:0] s2_amp;
  logic [DAC_W-1:0] s2_shape;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_wrap  <= 1'b0;
      s2_mode  <= MODE_SINE;
      s2_amp   <= '0;
      s2_shape <= '0;
    end else if (!en) begin
      s2_valid <= 1'b0;
      s2_wrap  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_wrap  <= s1_wrap;
      s2_mode  <= s1_mode;
      s2_amp   <= s1_amp;
      s2_shape <= shape_raw;
    end
  end

  logic [DAC_W-1:0]         raw, sample_next;
  logic signed [DAC_W:0]    centered;
  logic signed [PROD_W-1:0] prod, scaled;

  // |centered * amp| < 2^(DAC_W-1+AMP_W), so the rescaled value always fits DAC_W bits.
  assign raw         = (s2_mode == MODE_SINE) ? rom_data : s2_shape;
  assign centered    = $signed({1'b0, raw}) - $signed({1'b0, MID});
  assign prod        = PROD_W'(centered) * $signed(PROD_W'({1'b0, s2_amp}));
  assign scaled      = prod >>> AMP_W;
  assign sample_next = DAC_W'(scaled + $signed(PROD_W'(MID)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_out   <= MID;
      dac_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (!en || !s2_valid) begin
      dac_out   <= MID;
      dac_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      dac_out   <= sample_next;
      dac_valid <= 1'b1;
      wrap      <= s2_wrap;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed self-checking bench for dds_wave_gen at default parameters.
module tb_dds_wave_gen;

  localparam int DAC_W = 14;
  localparam logic [23:0] F1 = 24'h800000;   // one table step per clock, 512-cycle period
  localparam logic [1:0] M_SINE = 2'b00, M_SQR = 2'b01, M_TRI = 2'b10, M_SAW = 2'b11;

  logic        clk = 1'b0;
  logic        rst, en, cfg_load, cfg_immediate, sync;
  logic [23:0] cfg_freq;
  logic [7:0]  cfg_amp, cfg_phase;
  logic [1:0]  cfg_mode;
  logic        cfg_busy, dac_valid, wrap;
  logic [13:0] dac_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_wave_gen dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_load      (cfg_load),
    .cfg_immediate (cfg_immediate),
    .cfg_freq      (cfg_freq),
    .cfg_amp       (cfg_amp),
    .cfg_phase     (cfg_phase),
    .cfg_mode      (cfg_mode),
    .cfg_busy      (cfg_busy),
    .sync          (sync),
    .dac_out       (dac_out),
    .dac_valid     (dac_valid),
    .wrap          (wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected non-sine sample k steps after phase zero, with freq F1.
  function automatic int model(input logic [1:0] mode, input int amp, input int phase, input int k);
    int p, raw, t, s;
    p = (k + phase * 2) % 512;
    case (mode)
      M_SQR:   raw = (p >= 256) ? 0 : 16383;
      M_TRI:   begin
        t = (p >= 256) ? (511 - ((2 * p) % 512)) : (2 * p);
        raw = t * 32;
      end
      default: raw = p * 32;
    endcase
    s = raw - 8192;
    return ((s * amp) >>> 8) + 8192;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; cfg_immediate = 1'b0; sync = 1'b0;
    cfg_freq = '0; cfg_amp = '0; cfg_phase = '0; cfg_mode = M_SINE;
    #2;
    checks++; if (dac_out !== 14'd8192) begin errors++; $display("FAIL reset_dac_out: got %0d expected 8192", dac_out); end
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_dac_valid: got %b expected 0", dac_valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_cfg_busy: got %b expected 0", cfg_busy); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_saw_startup();
    int exp;
    cfg_freq = F1; cfg_amp = 8'd255; cfg_phase = 8'd0; cfg_mode = M_SAW;
    cfg_immediate = 1'b1; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0; en = 1'b1;
    tick();
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL startup_valid_c1: got %b expected 0", dac_valid); end
    tick();
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL startup_valid_c2: got %b expected 0", dac_valid); end
    for (int k = 0; k < 16; k++) begin
      tick();
      exp = model(M_SAW, 255, 0, k);
      checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL startup_valid k=%0d: got %b expected 1", k, dac_valid); end
      checks++; if (dac_out !== DAC_W'(exp)) begin errors++; $display("FAIL startup_saw k=%0d: got %0d expected %0d", k, dac_out, exp); end
    end
  endtask

  // Immediate load plus sync restart, then compare n samples against the model.
  task automatic test_mode(input string name, input logic [1:0] mode, input int amp, input int phase, input int n);
    int exp;
    cfg_freq = F1; cfg_amp = 8'(amp); cfg_phase = 8'(phase); cfg_mode = mode;
    cfg_immediate = 1'b1; cfg_load = 1'b1; sync = 1'b1;
    tick();
    cfg_load = 1'b0; sync = 1'b0;
    tick(); tick();
    for (int k = 0; k < n; k++) begin
      tick();
      exp = model(mode, amp, phase, k);
      checks++; if (dac_out !== DAC_W'(exp)) begin errors++; $display("FAIL %s_sample k=%0d: got %0d expected %0d", name, k, dac_out, exp); end
      checks++; if (wrap !== (k == 512)) begin errors++; $display("FAIL %s_wrap k=%0d: got %b expected %b", name, k, wrap, (k == 512)); end
    end
  endtask

  task automatic test_sine();
    int lo = 16383;
    int hi = 0;
    cfg_freq = F1; cfg_amp = 8'd128; cfg_phase = 8'd0; cfg_mode = M_SINE;
    cfg_immediate = 1'b1; cfg_load = 1'b1; sync = 1'b1;
    tick();
    cfg_load = 1'b0; sync = 1'b0;
    tick(); tick();
    for (int k = 0; k < 512; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (dac_out !== 14'd8192) begin errors++; $display("FAIL sine_zero_phase: got %0d expected 8192", dac_out); end
      end
      checks++;
      if (int'(dac_out) < 4096 || int'(dac_out) > 12287) begin
        errors++; $display("FAIL sine_range k=%0d: got %0d expected within 4096..12287", k, dac_out);
      end
      if (int'(dac_out) < lo) lo = int'(dac_out);
      if (int'(dac_out) > hi) hi = int'(dac_out);
    end
    checks++; if (hi < 12200) begin errors++; $display("FAIL sine_peak_hi: got %0d expected >= 12200", hi); end
    checks++; if (lo > 4200) begin errors++; $display("FAIL sine_peak_lo: got %0d expected <= 4200", lo); end
  endtask

  task automatic test_deferred();
    int exp;
    cfg_freq = F1; cfg_amp = 8'd255; cfg_phase = 8'd0; cfg_mode = M_SAW;
    cfg_immediate = 1'b1; cfg_load = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0; cfg_load = 1'b0;
    for (int cyc = 1; cyc <= 530; cyc++) begin
      cfg_load = 1'b0;
      if (cyc == 100) begin cfg_load = 1'b1; cfg_immediate = 1'b0; cfg_freq = 24'h200000; end
      if (cyc == 110) begin cfg_load = 1'b1; cfg_immediate = 1'b0; cfg_freq = 24'h400000; end
      tick();
      cfg_load = 1'b0;
      if (cyc == 100 || cyc == 511) begin
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL deferred_busy cyc=%0d: got %b expected 1", cyc, cfg_busy); end
      end
      if (cyc == 512) begin
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL deferred_idle cyc=%0d: got %b expected 0", cyc, cfg_busy); end
      end
      if (cyc >= 3) begin
        if (cyc <= 514)      exp = model(M_SAW, 255, 0, cyc - 3);
        else                 exp = model(M_SAW, 255, 0, (cyc - 515) >> 1);
        checks++; if (dac_out !== DAC_W'(exp)) begin errors++; $display("FAIL deferred_sample cyc=%0d: got %0d expected %0d", cyc, dac_out, exp); end
        checks++; if (wrap !== (cyc == 515)) begin errors++; $display("FAIL deferred_wrap cyc=%0d: got %b expected %b", cyc, wrap, (cyc == 515)); end
      end
    end
  endtask

  task automatic test_enable();
    int exp;
    cfg_freq = F1; cfg_amp = 8'd255; cfg_phase = 8'd0; cfg_mode = M_SAW;
    cfg_immediate = 1'b1; cfg_load = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0; cfg_load = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      en = !(cyc >= 50 && cyc < 60);
      tick();
      if (cyc >= 3 && cyc <= 49) begin
        exp = model(M_SAW, 255, 0, cyc - 3);
        checks++; if (dac_valid !== 1'b1 || dac_out !== DAC_W'(exp)) begin errors++; $display("FAIL enable_run cyc=%0d: got %0d/%b expected %0d/1", cyc, dac_out, dac_valid, exp); end
      end else if (cyc >= 50 && cyc <= 61) begin
        checks++; if (dac_valid !== 1'b0 || dac_out !== 14'd8192) begin errors++; $display("FAIL enable_off cyc=%0d: got %0d/%b expected 8192/0", cyc, dac_out, dac_valid); end
      end else if (cyc >= 62) begin
        exp = model(M_SAW, 255, 0, cyc - 13);
        checks++; if (dac_valid !== 1'b1 || dac_out !== DAC_W'(exp)) begin errors++; $display("FAIL enable_resume cyc=%0d: got %0d/%b expected %0d/1", cyc, dac_out, dac_valid, exp); end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    int exp;
    cfg_freq = 24'h400000; cfg_immediate = 1'b0; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", cfg_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dac_out !== 14'd8192) begin errors++; $display("FAIL areset_dac_out: got %0d expected 8192", dac_out); end
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", dac_valid); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", cfg_busy); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap: got %b expected 0", wrap); end
    tick();
    checks++; if (dac_out !== 14'd8192 || dac_valid !== 1'b0) begin errors++; $display("FAIL areset_hold: got %0d/%b expected 8192/0", dac_out, dac_valid); end
    rst = 1'b0;
    cfg_freq = F1; cfg_amp = 8'd255; cfg_phase = 8'd0; cfg_mode = M_SAW;
    cfg_immediate = 1'b0; cfg_load = 1'b1; en = 1'b1;
    tick();
    cfg_load = 1'b0;
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL freq0_load_busy: got %b expected 0", cfg_busy); end
    tick(); tick();
    checks++; if (dac_valid !== 1'b1 || dac_out !== 14'd8192) begin errors++; $display("FAIL post_reset_amp0: got %0d/%b expected 8192/1", dac_out, dac_valid); end
    for (int k = 0; k < 2; k++) begin
      tick();
      exp = model(M_SAW, 255, 0, k);
      checks++; if (dac_out !== DAC_W'(exp)) begin errors++; $display("FAIL post_reset_saw k=%0d: got %0d expected %0d", k, dac_out, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_saw_startup();
    test_mode("saw", M_SAW, 255, 0, 520);
    test_mode("tri", M_TRI, 200, 0, 300);
    test_mode("square_p0", M_SQR, 255, 0, 300);
    test_mode("square_p128", M_SQR, 255, 128, 300);
    test_mode("amp_zero", M_SAW, 0, 0, 40);
    test_sine();
    test_deferred();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
